pong_frame_scheduler: RTL and testbench

Sequences per-frame game-state updates for the Pong datapath. The block watches the 640x480 VGA pixel position and tick, detects the start of vertical blanking, and walks four update clients through a one-hot request/acknowledge handshake so that object positions change only while nothing is being drawn. It sits between the VGA timing generator and the paddle, ball and score logic. It reports per-client timeouts and a blanking overrun.

---
 rtl/pong_frame_scheduler.sv | 158 +++++++++++++++
 tb/tb_pong_frame_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_scheduler.sv
// pong_frame_scheduler
// Steps four game-state update clients through a one-hot request/acknowledge
// handshake once per frame. A sequence starts at the start of vertical blanking,
// so positions and score change only while nothing is being drawn.
//
// Ports
//   clk_100MHz   system clock
//   reset        synchronous, active-high reset
//   p_tick       pixel-tick strobe from the VGA timing generator
//   x, y         current pixel column / row
//   run          game running; gates the start of new sequences only
//   upd_ack      per-client acknowledge (0 = left paddle, 1 = right paddle,
//                2 = ball, 3 = score)
//   err_clr      clears overrun and timeout_err
//   upd_req      registered one-hot update request
//   busy         a sequence is in progress
//   frame_cnt    count of frame events, wraps
//   timeout_err  sticky per-client timeout flags
//   overrun      sticky: a sequence was still running when display restarted
//
// state | meaning
// IDLE  | waiting for the frame event (first column of row VD)
// REQ0  | requesting update from the left paddle
// REQ1  | requesting update from the right paddle
// REQ2  | requesting update from the ball
// REQ3  | requesting update from the score
module pong_frame_scheduler #(
  parameter int HD      = 640,
  parameter int VD      = 480,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        run,
  input  logic [3:0]  upd_ack,
  input  logic        err_clr,
  output logic [3:0]  upd_req,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [3:0]  timeout_err,
  output logic        overrun
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    REQ1 = 3'd2,
    REQ2 = 3'd3,
    REQ3 = 3'd4
  } state_t;

  state_t        state_q, state_d, adv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    req_q, req_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_q, frame_d;
  logic [3:0]    terr_q, terr_d;
  logic          ovr_q, ovr_d;
  logic [1:0]    idx;
  logic          ack_cur;
  logic          col0, fe, ds;

  // Both events sit on the first displayed column of their row.
  assign col0 = p_tick && (x == 10'd0) && (HD > 0);
  assign fe   = col0 && (y == 10'(VD));
  assign ds   = col0 && (y == 10'd0);

  always_comb begin
    idx = 2'd0;
    adv = REQ1;
    case (state_q)
      REQ1:    begin idx = 2'd1; adv = REQ2; end
      REQ2:    begin idx = 2'd2; adv = REQ3; end
      REQ3:    begin idx = 2'd3; adv = IDLE; end
      default: begin idx = 2'd0; adv = REQ1; end
    endcase
    ack_cur = upd_ack[idx];

    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = fe ? frame_q + 16'd1 : frame_q;
    // Clear first, then any set below overrides it in the same cycle.
    terr_d  = err_clr ? 4'd0 : terr_q;
    ovr_d   = err_clr ? 1'b0 : ovr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fe && run) state_d = REQ0;
      end
      REQ0, REQ1, REQ2, REQ3: begin
        // Display restart aborts the sequence ahead of ack or timeout.
        if (ds) begin
          state_d = IDLE;
          cnt_d   = '0;
          ovr_d   = 1'b1;
        end else if (ack_cur) begin
          state_d = adv;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = adv;
          cnt_d       = '0;
          terr_d[idx] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_d = 4'b0000;
    case (state_d)
      REQ0:    req_d = 4'b0001;
      REQ1:    req_d = 4'b0010;
      REQ2:    req_d = 4'b0100;
      REQ3:    req_d = 4'b1000;
      default: req_d = 4'b0000;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 4'b0000;
      busy_q  <= 1'b0;
      frame_q <= 16'd0;
      terr_q  <= 4'b0000;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign upd_req     = req_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Bench for pong_frame_scheduler: directed scenarios with literal expectations
// followed by randomized stimulus, all checked cycle by cycle against a
// behavioural model (current client number and how long its request has been up).
module tb_pong_frame_scheduler;

  localparam int HD = 640;
  localparam int VD = 480;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, p_tick, run, err_clr;
  logic [9:0]  x, y;
  logic [3:0]  upd_ack;
  logic [3:0]  upd_req, timeout_err;
  logic        busy, overrun;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  pong_frame_scheduler #(.HD(HD), .VD(VD), .TIMEOUT(TO)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .run        (run),
    .upd_ack    (upd_ack),
    .err_clr    (err_clr),
    .upd_req    (upd_req),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .timeout_err(timeout_err),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // model: m_stage = client being asked (-1 none), m_age = cycles its request has been visible
  int          m_stage = -1;
  int          m_age   = 0;
  logic [15:0] m_fc    = 16'd0;
  logic [3:0]  m_terr  = 4'd0;
  logic        m_ovr   = 1'b0;

  int hi_cnt[4];
  int busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit fe, ds, acked;
    if (reset) begin
      m_stage = -1; m_age = 0; m_fc = 16'd0; m_terr = 4'd0; m_ovr = 1'b0;
      return;
    end
    fe = p_tick && (x == 10'd0) && (y == 10'(VD));
    ds = p_tick && (x == 10'd0) && (y == 10'd0);
    if (err_clr) begin m_terr = 4'd0; m_ovr = 1'b0; end
    if (fe) m_fc = m_fc + 16'd1;
    if (m_stage < 0) begin
      if (fe && run) begin m_stage = 0; m_age = 1; end
    end else if (ds) begin
      m_stage = -1; m_ovr = 1'b1;
    end else begin
      acked = upd_ack[m_stage];
      if (acked || m_age == TO) begin
        if (!acked) m_terr[m_stage] = 1'b1;
        m_stage = (m_stage == 3) ? -1 : m_stage + 1;
        m_age = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] exp_req;
    model_edge();
    @(posedge clk);
    #1;
    exp_req = (m_stage < 0) ? 4'd0 : 4'(1 << m_stage);
    chk("upd_req", upd_req, exp_req);
    chk("busy", busy, (m_stage >= 0));
    chk("frame_cnt", frame_cnt, m_fc);
    chk("timeout_err", timeout_err, m_terr);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic idle_pos();
    p_tick = 1'b0; x = 10'd5; y = 10'd5;
  endtask

  task automatic fe_pulse();
    p_tick = 1'b1; x = 10'd0; y = 10'(VD);
    tick();
    idle_pos();
  endtask

  task automatic ds_pulse();
    p_tick = 1'b1; x = 10'd0; y = 10'd0;
    tick();
    idle_pos();
  endtask

  // Frame event, then each client acks d cycles after its request rises (-1 = never).
  task automatic run_seq(input int d0, input int d1, input int d2, input int d3, input bit drop_run);
    int dd[4];
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    busy_cnt = 0;
    fe_pulse();
    for (int n = 0; n < 200 && m_stage >= 0; n++) begin
      busy_cnt += int'(busy);
      for (int i = 0; i < 4; i++) hi_cnt[i] += int'(upd_req[i]);
      upd_ack = 4'd0;
      if (drop_run && m_stage == 1) run = 1'b0;
      if (dd[m_stage] >= 0 && m_age == dd[m_stage] + 1) upd_ack[m_stage] = 1'b1;
      tick();
    end
    upd_ack = 4'd0;
    chk("seq_done_busy", busy, 1'b0);
  endtask

  initial begin
    int r, ack_pct;
    reset = 1'b1; run = 1'b0; err_clr = 1'b0; upd_ack = 4'd0;
    idle_pos();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_req", upd_req, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fc", frame_cnt, 16'd0);
    chk("rst_terr", timeout_err, 4'd0);
    chk("rst_ovr", overrun, 1'b0);

    // normal sequence, ack 3 cycles after each request rises
    run = 1'b1;
    run_seq(3, 3, 3, 3, 1'b0);
    for (int i = 0; i < 4; i++) chk("norm_req_len", hi_cnt[i], 4);
    chk("norm_busy_len", busy_cnt, 16);
    chk("norm_fc", frame_cnt, 16'd1);
    chk("norm_terr", timeout_err, 4'd0);
    chk("norm_ovr", overrun, 1'b0);

    // client 2 never acks
    run_seq(0, 0, -1, 0, 1'b0);
    chk("to_req2_len", hi_cnt[2], 16);
    chk("to_req3_len", hi_cnt[3], 1);
    chk("to_busy_len", busy_cnt, 19);
    chk("to_terr", timeout_err, 4'b0100);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_terr", timeout_err, 4'd0);

    // display restart while client 0 stalls
    fe_pulse();
    repeat (3) tick();
    ds_pulse();
    chk("ovr_req", upd_req, 4'd0);
    chk("ovr_busy", busy, 1'b0);
    chk("ovr_flag", overrun, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // run gating and frame counting
    reset = 1'b1; tick(); reset = 1'b0;
    run = 1'b0;
    repeat (3) begin fe_pulse(); tick(); end
    chk("gate_fc", frame_cnt, 16'd3);
    chk("gate_req", upd_req, 4'd0);
    run = 1'b1;
    run_seq(0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) chk("droprun_req_len", hi_cnt[i], 1);
    chk("droprun_busy_len", busy_cnt, 4);
    fe_pulse();
    chk("gated_busy", busy, 1'b0);
    chk("gated_fc", frame_cnt, 16'd5);

    // ack on the wrong index is ignored
    run = 1'b1;
    fe_pulse();
    upd_ack = 4'b1000; tick(); tick();
    chk("wrong_ack_req", upd_req, 4'b0001);
    upd_ack = 4'b0001; tick(); upd_ack = 4'd0;
    chk("right_ack_req", upd_req, 4'b0010);
    ds_pulse();
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // ack lands on the timeout cycle
    run_seq(15, 0, 0, 0, 1'b0);
    chk("late_ack_len", hi_cnt[0], 16);
    chk("late_ack_terr", timeout_err, 4'd0);

    // err_clr coincides with a new timeout
    fe_pulse();
    repeat (15) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_vs_set_terr", timeout_err, 4'b0001);
    chk("clr_vs_set_req", upd_req, 4'b0010);
    ds_pulse();

    // reset during REQ2
    fe_pulse();
    upd_ack = 4'b0001; tick();
    upd_ack = 4'b0010; tick();
    upd_ack = 4'd0;
    chk("pre_rst_req", upd_req, 4'b0100);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_req", upd_req, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fc", frame_cnt, 16'd0);
    chk("mid_rst_terr", timeout_err, 4'd0);
    chk("mid_rst_ovr", overrun, 1'b0);
    fe_pulse();
    chk("restart_req", upd_req, 4'b0001);
    ds_pulse();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      ack_pct = (n < 2000) ? 30 : 4;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        p_tick = 1'b1; x = 10'd0; y = 10'(VD);
      end else if (r < 5) begin
        p_tick = 1'b1; x = 10'd0; y = 10'd0;
      end else if (r < 25) begin
        p_tick = ($urandom_range(0, 1) == 0); x = 10'd0; y = 10'($urandom_range(0, 524));
      end else begin
        p_tick = ($urandom_range(0, 3) == 0);
        x = 10'($urandom_range(0, 799));
        y = 10'($urandom_range(0, 524));
      end
      run = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 4; i++) upd_ack[i] = ($urandom_range(0, 99) < ack_pct);
      err_clr = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
